// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory requests for loads/stores
// and registers the result (ALU pass-through or extended load data) for WB.
module mem_access #(
    parameter int X0_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_sdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
        OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8
    } op_t;

    state_t      state, state_n;
    op_t         op_q;
    logic [31:0] addr_q, sdata_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    logic        ex_load, ex_store, ex_mis, st_q, latch;
    logic [4:0]  wd_n;
    logic        wreg_n, mis_n;
    logic [31:0] wdata_n, load_val;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign ex_ready = rst && (state == IDLE);
    assign st_q     = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

    always_comb begin
        ex_load  = 1'b0;
        ex_store = 1'b0;
        ex_mis   = 1'b0;
        case (ex_mem_op)
            OP_LB, OP_LBU: ex_load = 1'b1;
            OP_LH, OP_LHU: begin ex_load = 1'b1; ex_mis = ex_mem_addr[0]; end
            OP_LW:         begin ex_load = 1'b1; ex_mis = |ex_mem_addr[1:0]; end
            OP_SB:         ex_store = 1'b1;
            OP_SH:         begin ex_store = 1'b1; ex_mis = ex_mem_addr[0]; end
            OP_SW:         begin ex_store = 1'b1; ex_mis = |ex_mem_addr[1:0]; end
            default: ;
        endcase
    end

    assign lb = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lh = dm_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (op_q)
            OP_LB:   load_val = {{24{lb[7]}}, lb};
            OP_LBU:  load_val = {24'b0, lb};
            OP_LH:   load_val = {{16{lh[15]}}, lh};
            OP_LHU:  load_val = {16'b0, lh};
            default: load_val = dm_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        wd_n    = '0;
        wreg_n  = 1'b0;
        wdata_n = '0;
        mis_n   = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mis) begin
                        mis_n = 1'b1;
                    end else if (ex_load || ex_store) begin
                        latch   = 1'b1;
                        state_n = REQ;
                    end else begin
                        wd_n    = ex_wd;
                        wreg_n  = ex_wreg;
                        wdata_n = ex_wdata;
                    end
                end
            end
            REQ: begin
                if (dm_gnt) state_n = st_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (dm_rvalid) begin
                    state_n = IDLE;
                    wd_n    = wd_q;
                    wreg_n  = wreg_q;
                    wdata_n = load_val;
                end
            end
            default: state_n = IDLE;
        endcase
        if (X0_SUPPRESS != 0 && wd_n == 5'd0) wreg_n = 1'b0;
    end

    // Request fields come only from latched values so they stay stable until grant.
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_be    = '0;
        dm_wdata = '0;
        if (rst && state == REQ) begin
            dm_req  = 1'b1;
            dm_we   = st_q;
            dm_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                OP_SB: begin
                    dm_be    = 4'b0001 << addr_q[1:0];
                    dm_wdata = {4{sdata_q[7:0]}};
                end
                OP_SH: begin
                    dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    dm_wdata = {2{sdata_q[15:0]}};
                end
                OP_SW: begin
                    dm_be    = 4'b1111;
                    dm_wdata = sdata_q;
                end
                default: dm_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_misalign <= 1'b0;
            op_q         <= OP_NONE;
            addr_q       <= '0;
            sdata_q      <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
        end else begin
            state        <= state_n;
            mem_wd       <= wd_n;
            mem_wreg     <= wreg_n;
            mem_wdata    <= wdata_n;
            mem_misalign <= mis_n;
            if (latch) begin
                op_q    <= op_t'(ex_mem_op);
                addr_q  <= ex_mem_addr;
                sdata_q <= ex_mem_sdata;
                wd_q    <= ex_wd;
                wreg_q  <= ex_wreg;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by random
// transactions checked against an arithmetic reference of the access rules.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_wreg;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata, ex_mem_addr, ex_mem_sdata;
    logic [3:0]  ex_mem_op;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_misalign;
    logic [31:0] mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.X0_SUPPRESS(1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // 0 = pass-through, 1 = misaligned, 2 = load, 3 = store
    function automatic int kind(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd0 || op > 4'd8) return 0;
        if ((op == 4'd2 || op == 4'd5 || op == 4'd7) && (a % 2) != 0) return 1;
        if ((op == 4'd3 || op == 4'd8) && (a % 4) != 0) return 1;
        return (op <= 4'd5) ? 2 : 3;
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd6) return 4'(32'd1 << (a % 4));
        if (op == 4'd7) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_sd(input logic [3:0] op, input logic [31:0] sd);
        if (op == 4'd6) return (sd & 32'hFF) * 32'h0101_0101;
        if (op == 4'd7) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> ((a % 4) * 8)) & 32'hFF;
        h = (d >> (((a % 4) / 2) * 16)) & 32'hFFFF;
        case (op)
            4'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            4'd4:    return b;
            4'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            4'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                       input int gd, input int rd, input logic [31:0] rdata, input logic rv_early);
        int k;
        int t;
        logic exp_wr;
        k = kind(op, a);
        exp_wr = wr && (wd != 5'd0);
        t = 0;
        while (!ex_ready && t < 50) begin @(negedge clk); t++; end
        chk("ready_before_accept", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_mem_op = op; ex_mem_addr = a; ex_mem_sdata = sd;
        ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_op = 4'($urandom); ex_mem_addr = $urandom;
        ex_mem_sdata = $urandom; ex_wd = 5'($urandom); ex_wdata = $urandom;
        if (k == 0) begin
            chk("pass_wd", 32'(mem_wd), 32'(wd));
            chk("pass_wreg", 32'(mem_wreg), 32'(exp_wr));
            chk("pass_wdata", mem_wdata, wdat);
            chk("pass_misalign", 32'(mem_misalign), 32'd0);
            chk("pass_ready", 32'(ex_ready), 32'd1);
            return;
        end
        if (k == 1) begin
            chk("mis_pulse", 32'(mem_misalign), 32'd1);
            chk("mis_wreg", 32'(mem_wreg), 32'd0);
            chk("mis_wdata", mem_wdata, 32'd0);
            chk("mis_req", 32'(dm_req), 32'd0);
            chk("mis_ready", 32'(ex_ready), 32'd1);
            @(negedge clk);
            chk("mis_pulse_end", 32'(mem_misalign), 32'd0);
            chk("mis_req_after", 32'(dm_req), 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            chk("req", 32'(dm_req), 32'd1);
            chk("req_we", 32'(dm_we), (k == 3) ? 32'd1 : 32'd0);
            chk("req_addr", dm_addr, a & 32'hFFFF_FFFC);
            chk("req_be", 32'(dm_be), 32'(exp_be(op, a)));
            if (k == 3) chk("req_wdata", dm_wdata, exp_sd(op, sd));
            chk("req_ready", 32'(ex_ready), 32'd0);
            chk("req_bubble", 32'(mem_wreg), 32'd0);
            if (i == gd) begin
                dm_gnt = 1'b1;
                dm_rvalid = rv_early;
                dm_rdata = $urandom;
            end
            @(negedge clk);
            dm_gnt = 1'b0; dm_rvalid = 1'b0;
        end
        chk("post_gnt_req", 32'(dm_req), 32'd0);
        chk("post_gnt_wreg", 32'(mem_wreg), 32'd0);
        chk("post_gnt_wdata", mem_wdata, 32'd0);
        if (k == 3) begin
            chk("store_ready", 32'(ex_ready), 32'd1);
            return;
        end
        for (int j = 0; j < rd; j++) begin
            chk("wait_ready", 32'(ex_ready), 32'd0);
            chk("wait_bubble", 32'(mem_wreg), 32'd0);
            chk("wait_req", 32'(dm_req), 32'd0);
            @(negedge clk);
        end
        dm_rvalid = 1'b1; dm_rdata = rdata;
        @(negedge clk);
        dm_rvalid = 1'b0; dm_rdata = $urandom;
        chk("load_wd", 32'(mem_wd), 32'(wd));
        chk("load_wreg", 32'(mem_wreg), 32'(exp_wr));
        chk("load_wdata", mem_wdata, exp_load(op, a, rdata));
        chk("load_ready", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ex_valid = 1'b0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
        ex_mem_op = '0; ex_mem_addr = '0; ex_mem_sdata = '0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ex_ready), 32'd0);
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_wreg", 32'(mem_wreg), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_misalign", 32'(mem_misalign), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ex_ready), 32'd1);
        chk("idle_bubble", mem_wdata, 32'd0);

        txn(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, 32'h0, 1'b0);
        txn(4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 2, 0, 32'h80FF_FF7F, 1'b0);
        chk("lb_example", mem_wdata, 32'hFFFF_FF80);
        txn(4'd4, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 2, 0, 32'h80FF_FF7F, 1'b0);
        chk("lbu_example", mem_wdata, 32'h0000_0080);
        txn(4'd7, 32'h22, 32'hABCD_BEEF, 5'd9, 1'b1, 32'h0, 1, 0, 32'h0, 1'b0);
        txn(4'd3, 32'h6, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'hCAFE, 0, 0, 32'h0, 1'b0);
        txn(4'd3, 32'h8, 32'h0, 5'd0, 1'b1, 32'h0, 0, 1, 32'h5, 1'b1);
        chk("x0_wdata", mem_wdata, 32'h5);
        txn(4'd12, 32'h7, 32'h0, 5'd2, 1'b1, 32'h77, 0, 0, 32'h0, 1'b0);
        txn(4'd0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h99, 0, 0, 32'h0, 1'b0);
        txn(4'd2, 32'h202, 32'h0, 5'd6, 1'b1, 32'h0, 0, 2, 32'h8001_1234, 1'b1);

        // reset while waiting for load data; late rvalid must be ignored
        ex_valid = 1'b1; ex_mem_op = 4'd3; ex_mem_addr = 32'h40; ex_wd = 5'd3; ex_wreg = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("rw_in_wait", 32'(ex_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_rst_ready", 32'(ex_ready), 32'd0);
        chk("rw_rst_req", 32'(dm_req), 32'd0);
        chk("rw_rst_be", 32'(dm_be), 32'd0);
        chk("rw_rst_wdata", mem_wdata, 32'd0);
        rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk("rw_no_wreg", 32'(mem_wreg), 32'd0);
        chk("rw_no_wd", 32'(mem_wd), 32'd0);
        chk("rw_no_wdata", mem_wdata, 32'd0);
        chk("rw_idle", 32'(ex_ready), 32'd1);

        for (int n = 0; n < 80; n++) begin
            txn(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 1'($urandom),
                $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rand_idle_bubble", 32'(mem_wreg), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
